// File: rtl/mod_counter_updown_oneshot_pkg.sv
// Shared constants and state encoding for the up/down one-shot mod counter
// family. Direction and mode literals are named here so that callers and
// sibling counters agree on their polarity.
package mod_counter_updown_oneshot_pkg;

  localparam logic DIR_UP       = 1'b1;
  localparam logic DIR_DOWN     = 1'b0;
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/mod_counter_next_value.sv
// Combinational step for a modulo-(FINAL_VALUE+1) counter.
// Ports:
//   q_i           current count
//   up_i          1 = increment, 0 = decrement
//   next_q_o      count after one step, wrapping explicitly at both ends
//   at_terminal_o q_i equals the terminal for the current direction
//                 (FINAL_VALUE going up, 0 going down)
module mod_counter_next_value
  import mod_counter_updown_oneshot_pkg::*;
#(
  parameter int FINAL_VALUE = 9,
  parameter int BITS        = $clog2(FINAL_VALUE + 1)
) (
  input  logic [BITS-1:0] q_i,
  input  logic            up_i,
  output logic [BITS-1:0] next_q_o,
  output logic            at_terminal_o
);

  localparam logic [BITS-1:0] FV = BITS'(FINAL_VALUE);

  logic is_max, is_zero;

  assign is_max  = (q_i == FV);
  assign is_zero = (q_i == '0);

  // Wrap is decoded rather than left to overflow so non-power-of-two
  // moduli never visit values above FINAL_VALUE.
  always_comb begin
    next_q_o = q_i;
    if (up_i == DIR_UP) next_q_o = is_max  ? '0 : q_i + 1'b1;
    else                next_q_o = is_zero ? FV : q_i - 1'b1;
  end

  assign at_terminal_o = (up_i == DIR_UP) ? is_max : is_zero;

endmodule

// File: rtl/mod_counter_updown_oneshot.sv
// Modulo-(FINAL_VALUE+1) up/down counter with sync clear, clamped parallel
// load and a one-shot mode that halts at the terminal value.
// Ports:
//   clk, reset   rising-edge clock, async active-high reset
//   enable       one step per clock while high
//   up           1 = count up, 0 = count down
//   oneshot      0 = wrap, 1 = halt at terminal
//   clear        sync clear (0 going up, FINAL_VALUE going down)
//   load         sync load of min(load_value, FINAL_VALUE)
//   Q            registered count
//   at_terminal  Q equals terminal for current direction (comb)
//   tick_out     carry/borrow pulse for cascading (comb, zero latency)
//   expired      registered, high while halted in one-shot mode
module mod_counter_updown_oneshot
  import mod_counter_updown_oneshot_pkg::*;
#(
  parameter int FINAL_VALUE = 9,
  parameter int BITS        = $clog2(FINAL_VALUE + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            up,
  input  logic            oneshot,
  input  logic            clear,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  output logic [BITS-1:0] Q,
  output logic            at_terminal,
  output logic            tick_out,
  output logic            expired
);

  localparam logic [BITS-1:0] FV = BITS'(FINAL_VALUE);

  logic [BITS-1:0] q_q, step_d, load_d;
  logic            expired_q;
  cnt_state_e      state_q;

  mod_counter_next_value #(
    .FINAL_VALUE (FINAL_VALUE),
    .BITS        (BITS)
  ) u_next (
    .q_i           (q_q),
    .up_i          (up),
    .next_q_o      (step_d),
    .at_terminal_o (at_terminal)
  );

  assign load_d = (load_value > FV) ? FV : load_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q       <= '0;
      expired_q <= 1'b0;
      state_q   <= RUN;
    end else if (clear) begin
      q_q       <= (up == DIR_UP) ? '0 : FV;
      expired_q <= 1'b0;
      state_q   <= RUN;
    end else if (load) begin
      q_q       <= load_d;
      expired_q <= 1'b0;
      state_q   <= RUN;
    end else if (state_q == RUN && enable) begin
      // One-shot stops on the terminal instead of wrapping; Q stays put.
      if (oneshot == MODE_ONESHOT && at_terminal) begin
        state_q   <= HALT;
        expired_q <= 1'b1;
      end else begin
        q_q <= step_d;
      end
    end
  end

  assign Q        = q_q;
  assign expired  = expired_q;
  assign tick_out = enable & at_terminal & ~clear & ~load & (state_q == RUN);

endmodule

// File: tb/tb_mod_counter_updown_oneshot.sv
module tb_mod_counter_updown_oneshot;

  logic       clk = 1'b0;
  logic       reset, enable, up, oneshot, clear, load;
  logic [3:0] load_value;
  logic [3:0] Q;
  logic       at_terminal, tick_out, expired;

  logic       ones_en;
  logic [3:0] ones_q;
  logic [2:0] tens_q;
  logic       ones_at, ones_tick, ones_exp;
  logic       tens_at, tens_tick, tens_exp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mod_counter_updown_oneshot #(.FINAL_VALUE(9)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .oneshot(oneshot),
    .clear(clear), .load(load), .load_value(load_value), .Q(Q),
    .at_terminal(at_terminal), .tick_out(tick_out), .expired(expired)
  );

  mod_counter_updown_oneshot #(.FINAL_VALUE(9)) u_ones (
    .clk(clk), .reset(reset), .enable(ones_en), .up(1'b1), .oneshot(1'b0),
    .clear(1'b0), .load(1'b0), .load_value(4'd0), .Q(ones_q),
    .at_terminal(ones_at), .tick_out(ones_tick), .expired(ones_exp)
  );

  mod_counter_updown_oneshot #(.FINAL_VALUE(5)) u_tens (
    .clk(clk), .reset(reset), .enable(ones_tick), .up(1'b1), .oneshot(1'b0),
    .clear(1'b0), .load(1'b0), .load_value(3'd0), .Q(tens_q),
    .at_terminal(tens_at), .tick_out(tens_tick), .expired(tens_exp)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tick_cnt;
    reset = 1'b1; enable = 1'b0; up = 1'b1; oneshot = 1'b0;
    clear = 1'b0; load = 1'b0; load_value = 4'd0; ones_en = 1'b0;
    #12;
    reset = 1'b0;
    #1;
    chk("reset_q", Q, 0);
    chk("reset_expired", expired, 0);

    // Wrap up-count: 0..9,0,1
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("up_q", Q, i % 10);
      chk("up_tick", tick_out, (i % 10 == 9) ? 1 : 0);
      chk("up_at", at_terminal, (i % 10 == 9) ? 1 : 0);
      tick();
    end
    chk("up_end_q", Q, 2);

    // Down-count from 2: 2,1,0,9 then 8
    up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dn_q", Q, (i < 3) ? 2 - i : 9);
      chk("dn_tick", tick_out, (i == 2) ? 1 : 0);
      tick();
    end
    chk("dn_end_q", Q, 8);

    // Load with enable high: load wins, no step
    up = 1'b1; oneshot = 1'b1; load = 1'b1; load_value = 4'd7;
    tick();
    load = 1'b0;
    chk("load_en_q", Q, 7);

    // One-shot: 7,8,9 then hold
    tick_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("os_q", Q, (i < 2) ? 7 + i : 9);
      chk("os_expired", expired, (i >= 3) ? 1 : 0);
      if (tick_out) tick_cnt++;
      tick();
    end
    chk("os_tick_count", tick_cnt, 1);
    chk("os_hold_q", Q, 9);
    chk("os_hold_expired", expired, 1);

    // Direction change and oneshot drop ignored while halted
    up = 1'b0; oneshot = 1'b0;
    #1;
    chk("halt_tick", tick_out, 0);
    tick();
    chk("halt_dir_q", Q, 9);
    chk("halt_keep_expired", expired, 1);

    // Clear releases (up mode -> 0)
    up = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; enable = 1'b0;
    chk("clr_q", Q, 0);
    chk("clr_expired", expired, 0);

    // Out-of-range load clamps
    load = 1'b1; load_value = 4'd13;
    tick();
    chk("clamp_q", Q, 9);

    // Clear beats load
    load_value = 4'd5; clear = 1'b1;
    tick();
    chk("clr_beats_load_q", Q, 0);
    load = 1'b0;

    // Clear in down mode goes to FINAL_VALUE
    up = 1'b0;
    tick();
    clear = 1'b0;
    chk("clr_down_q", Q, 9);

    // Async reset mid-cycle while Q=5
    up = 1'b1; load = 1'b1; load_value = 4'd5;
    tick();
    load = 1'b0;
    chk("pre_rst_q", Q, 5);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_q", Q, 0);
    reset = 1'b0;

    // Async reset while expired
    oneshot = 1'b1; enable = 1'b1; load = 1'b1; load_value = 4'd9;
    tick();
    load = 1'b0;
    tick();
    chk("pre_rst_expired", expired, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_exp_q", Q, 0);
    chk("async_rst_exp_expired", expired, 0);
    reset = 1'b0; enable = 1'b0; oneshot = 1'b0;

    // Cascade: ones (mod 10) drives tens (mod 6)
    ones_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      chk("casc_ones", ones_q, i % 10);
      chk("casc_tens", tens_q, (i / 10) % 6);
      tick();
    end
    chk("casc_end_ones", ones_q, 0);
    chk("casc_end_tens", tens_q, 0);
    ones_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
